// File: rtl/mandel_pixel_scan.sv
// Raster scanner for the Mandelbrot pipeline: issues one complex coordinate
// per clock and carries a matching pixel tag through a delay line so that
// the tag emerges together with the pipeline result for that pixel.
module mandel_pixel_scan #(
  parameter int WIDTH   = 20,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int LATENCY = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    hold,
  input  logic signed [WIDTH-1:0] re_min,
  input  logic signed [WIDTH-1:0] im_max,
  input  logic signed [WIDTH-1:0] re_step,
  input  logic signed [WIDTH-1:0] im_step,
  output logic signed [WIDTH-1:0] c_real,
  output logic signed [WIDTH-1:0] c_imag,
  output logic                    busy,
  output logic                    tag_valid,
  output logic [XW-1:0]           tag_x,
  output logic [YW-1:0]           tag_y,
  output logic                    tag_last,
  output logic                    done
);

  localparam logic [XW-1:0] XMAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] YMAX = YW'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t state, state_nxt;

  logic          issue_first;
  logic          issue_step;
  logic          push_vld;
  logic          push_last;
  logic          eol;
  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;

  logic signed [WIDTH-1:0] re_min_q;
  logic signed [WIDTH-1:0] re_step_q;
  logic signed [WIDTH-1:0] im_step_q;

  // Tag delay line: stage 0 is written at the issuing edge, stage LATENCY
  // drives the tag outputs LATENCY edges later.
  logic [LATENCY:0] vld_p;
  logic [LATENCY:0] last_p;
  logic [XW-1:0]    x_p [0:LATENCY];
  logic [YW-1:0]    y_p [0:LATENCY];

  assign busy      = (state != IDLE);
  assign tag_valid = vld_p[LATENCY];
  assign tag_last  = last_p[LATENCY];
  assign tag_x     = x_p[LATENCY];
  assign tag_y     = y_p[LATENCY];
  assign done      = vld_p[LATENCY] & last_p[LATENCY];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and issue decisions, including the next raster position.
  always_comb begin
    state_nxt   = state;
    issue_first = 1'b0;
    issue_step  = 1'b0;
    x_nxt       = x;
    y_nxt       = y;
    eol         = (x == XMAX);
    case (state)
      IDLE: begin
        if (start) begin
          issue_first = 1'b1;
          x_nxt       = '0;
          y_nxt       = '0;
          // A single-pixel frame has already issued its last pixel here.
          if (XMAX == '0 && YMAX == '0) state_nxt = DRAIN;
          else                          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (!hold) begin
          issue_step = 1'b1;
          if (eol) begin
            x_nxt = '0;
            y_nxt = y + 1'b1;
          end else begin
            x_nxt = x + 1'b1;
          end
          if (x_nxt == XMAX && y_nxt == YMAX) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    push_vld  = issue_first | issue_step;
    push_last = push_vld && (x_nxt == XMAX) && (y_nxt == YMAX);
  end

  // Raster position counters follow the issued pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

  // Coordinate generation: latch frame parameters on start, step per issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_real    <= '0;
      c_imag    <= '0;
      re_min_q  <= '0;
      re_step_q <= '0;
      im_step_q <= '0;
    end else if (issue_first) begin
      c_real    <= re_min;
      c_imag    <= im_max;
      re_min_q  <= re_min;
      re_step_q <= re_step;
      im_step_q <= im_step;
    end else if (issue_step) begin
      if (eol) begin
        c_real <= re_min_q;
        c_imag <= c_imag - im_step_q;
      end else begin
        c_real <= c_real + re_step_q;
      end
    end
  end

  // Tag delay line shifts every edge; bubbles keep their slot positions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p  <= '0;
      last_p <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        x_p[i] <= '0;
        y_p[i] <= '0;
      end
    end else begin
      vld_p  <= {vld_p[LATENCY-1:0], push_vld};
      last_p <= {last_p[LATENCY-1:0], push_last};
      x_p[0] <= x_nxt;
      y_p[0] <= y_nxt;
      for (int i = 1; i <= LATENCY; i++) begin
        x_p[i] <= x_p[i-1];
        y_p[i] <= y_p[i-1];
      end
    end
  end

endmodule
